// File: rtl/input_skew_buffer.sv
// Diagonal input skew stage feeding the west edge of the systolic PE array.
// Lane i delays its element by i+1 enabled register stages; done pulses once the last vector clears lane NUM_LANES-1.

module skew_lane #(
   parameter int DEPTH      = 1,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  adv,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_data
);
   logic [DEPTH-1:0]                 vld_pipe_q, vld_pipe_d;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      dat_pipe_d = dat_pipe_q;
      if (adv) begin
         // Bubbles carry zero data so the array never sees stale operands.
         vld_pipe_d[0] = in_vld;
         dat_pipe_d[0] = in_vld ? in_data : '0;
         for (int s = 1; s < DEPTH; s++) begin
            vld_pipe_d[s] = vld_pipe_q[s-1];
            dat_pipe_d[s] = dat_pipe_q[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         dat_pipe_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         dat_pipe_q <= dat_pipe_d;
      end
   end

   assign out_vld  = vld_pipe_q[DEPTH-1];
   assign out_data = dat_pipe_q[DEPTH-1];
endmodule

module input_skew_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_LANES  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            array_en,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            in_last,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
   output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
   output logic [NUM_LANES-1:0]            out_valid,
   output logic                            done
);
   localparam int CNT_W = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             adv, accept;

   assign adv      = array_en && !rst;
   assign in_ready = adv && (state_q != DRAIN);
   assign accept   = in_valid && in_ready;
   assign done     = done_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      if (adv) begin
         done_d = 1'b0;
         unique case (state_q)
            IDLE, STREAM: begin
               if (accept) begin
                  state_d = in_last ? DRAIN : STREAM;
                  cnt_d   = '0;
               end
            end
            DRAIN: begin
               // NUM_LANES-1 drain advances: the last one lands on the deepest lane.
               if (cnt_q == CNT_W'(NUM_LANES-2)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      skew_lane #(
         .DEPTH      (i+1),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .adv      (adv),
         .in_vld   (accept),
         .in_data  (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
         .out_vld  (out_valid[i]),
         .out_data (out_data[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end
endmodule

// File: tb/tb_input_skew_buffer.sv
// Directed bench for input_skew_buffer (NUM_LANES=4, DATA_WIDTH=8).
// Checks reset, single/back-to-back vectors, stall, bubble and reset during drain.

module tb_input_skew_buffer;
   localparam int DW = 8;
   localparam int NL = 4;
   localparam int W  = DW*NL;

   logic          clk = 1'b0;
   logic          rst, array_en, in_valid, in_ready, in_last, done;
   logic [W-1:0]  in_data, out_data;
   logic [NL-1:0] out_valid;

   int n_chk  = 0;
   int n_pass = 0;

   logic [W-1:0] sd [8];
   bit           sv [8];

   always #5 clk = ~clk;

   input_skew_buffer #(.DATA_WIDTH(DW), .NUM_LANES(NL)) dut (
      .clk       (clk),
      .rst       (rst),
      .array_en  (array_en),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] ed, input logic [NL-1:0] ev,
                          input logic edone, input logic erdy);
      chk({tag, "_data"},  64'(out_data),  64'(ed));
      chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
      chk({tag, "_done"},  64'(done),      64'(edone));
      chk({tag, "_ready"}, 64'(in_ready),  64'(erdy));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Diagonal model: after advance a, lane j holds slot a-j.
   task automatic expect_at(input int a, input int n, output logic [W-1:0] ed, output logic [NL-1:0] ev);
      ed = '0;
      ev = '0;
      for (int j = 0; j < NL; j++) begin
         int s;
         s = a - j;
         if (s >= 0 && s < n && sv[s]) begin
            ed[j*DW +: DW] = sd[s][j*DW +: DW];
            ev[j] = 1'b1;
         end
      end
   endtask

   task automatic drive_slot(input int s, input int n);
      in_valid = sv[s];
      in_data  = sd[s];
      in_last  = (s == n-1) || !sv[s];
   endtask

   task automatic run_scn(input string tag, input int n, input int stall_after, input int stall_len);
      int a;
      int st;
      logic [W-1:0]  ed;
      logic [NL-1:0] ev;
      a  = 0;
      st = 0;
      while (a < n + NL) begin
         if (a == stall_after + 1 && st < stall_len) begin
            array_en = 1'b0;
            if (a < n) drive_slot(a, n);
            step();
            st++;
            expect_at(a-1, n, ed, ev);
            chk_out($sformatf("%s_stall%0d", tag, st), ed, ev, (a-1) == n+NL-2, 1'b0);
         end else begin
            array_en = 1'b1;
            if (a < n) drive_slot(a, n);
            else begin
               in_valid = 1'b0;
               in_last  = 1'b0;
               in_data  = 32'hCAFE_F00D;
            end
            step();
            expect_at(a, n, ed, ev);
            chk_out($sformatf("%s_e%0d", tag, a), ed, ev, a == n+NL-2, !(a >= n-1 && a < n+NL-2));
            a++;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int k);
      in_valid = 1'b0;
      in_last  = 1'b0;
      array_en = 1'b1;
      for (int i = 0; i < k; i++) step();
   endtask

   initial begin
      // Reset with noisy inputs and the array enabled.
      rst      = 1'b1;
      array_en = 1'b1;
      in_valid = 1'b1;
      in_last  = 1'($urandom);
      in_data  = $urandom;
      step();
      chk_out("rst0", '0, '0, 1'b0, 1'b0);
      in_data = $urandom;
      in_last = 1'($urandom);
      step();
      chk_out("rst1", '0, '0, 1'b0, 1'b0);
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      chk("rst_release_ready", 64'(in_ready), 64'd1);

      // Single last vector, hand-computed diagonal.
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 32'h4433_2211;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 32'hDEAD_BEEF;
      chk_out("s2_e0", 32'h0000_0011, 4'b0001, 1'b0, 1'b0);
      step();
      chk_out("s2_e1", 32'h0000_2200, 4'b0010, 1'b0, 1'b0);
      step();
      chk_out("s2_e2", 32'h0033_0000, 4'b0100, 1'b0, 1'b0);
      step();
      chk_out("s2_e3", 32'h4400_0000, 4'b1000, 1'b1, 1'b1);
      step();
      chk_out("s2_e4", '0, '0, 1'b0, 1'b1);
      idle(2);

      // Back-to-back A,B,C.
      sd[0] = 32'hA3A2_A1A0; sv[0] = 1'b1;
      sd[1] = 32'hB3B2_B1B0; sv[1] = 1'b1;
      sd[2] = 32'hC3C2_C1C0; sv[2] = 1'b1;
      run_scn("s3", 3, -1, 0);
      idle(2);

      // Same stream, two-cycle array stall right after B is accepted.
      run_scn("s4", 3, 1, 2);
      idle(2);

      // One bubble between A and B; in_last during the bubble must be ignored.
      sd[0] = 32'h1312_1110; sv[0] = 1'b1;
      sd[1] = 32'h5555_5555; sv[1] = 1'b0;
      sd[2] = 32'h2322_2120; sv[2] = 1'b1;
      run_scn("s5", 3, -1, 0);
      idle(2);

      // Reset in the middle of a drain discards the pending done.
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = 32'h4433_2211;
      step();
      chk_out("s6_e0", 32'h0000_0011, 4'b0001, 1'b0, 1'b0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst      = 1'b1;
      step();
      chk_out("s6_rst", '0, '0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < NL; i++) begin
         step();
         chk_out($sformatf("s6_post%0d", i), '0, '0, 1'b0, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/input_skew_buffer.md
# input_skew_buffer

Input skew stage that sits between the activation buffer and the west edge of the systolic PE array. It accepts one NUM_LANES-wide activation vector per cycle over a valid/ready handshake. It delays lane i by i+1 enabled register stages, built as chains of enabled DFFs, so elements enter the array diagonally. After the vector flagged last is accepted, it drains the chains and pulses done.

## Interface
- DATA_WIDTH, 8, bits per activation element
- NUM_LANES, 4, lanes / PE rows; legal range 2..64
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- array_en  in  1  global advance enable shared with the PE array; 0 freezes all state
- in_valid  in  1  upstream vector valid
- in_ready  out  1  combinational: array_en && !rst && state != DRAIN
- in_last  in  1  qualifies the accepted vector as the final one of a tile
- in_data  in  NUM_LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_data  out  NUM_LANES*DATA_WIDTH  skewed lane data, same packing
- out_valid  out  NUM_LANES  per-lane valid accompanying out_data
- done  out  1  one-cycle pulse: last vector's lane NUM_LANES-1 is on the output

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Advance: any rising edge with array_en=1 and rst=0. With array_en=0, every register holds, including state, counter and done.
- Lane i is a chain of i+1 registers carrying {valid, data}, with output taken from the final register.
- On advance, stage 0 of every lane loads {1, in_data lane} if accept, else {0, 0} (bubble). Deeper stages shift.
- Bubbles: an advance without accept injects out_valid=0, data 0. They propagate diagonally like real data.
- FSM:
  - IDLE: accept && !in_last -> STREAM; accept && in_last -> DRAIN with cnt=0.
  - STREAM: accept && in_last -> DRAIN with cnt=0; otherwise stay, including bubble advances.
  - DRAIN: in_ready=0; each advance injects a bubble and increments cnt. When an advance occurs with cnt == NUM_LANES-2, go to IDLE and set done=1 for one cycle.
- done is registered. It is cleared on the next advance and held while array_en=0.
- cnt width: clog2(NUM_LANES) bits, minimum 1; it never wraps.
- Reset (any state, including mid-DRAIN):
  - state=IDLE, cnt=0.
  - All chain registers {0,0}, so out_data=0 and out_valid=0.
  - done=0, and a pending done is discarded.
  - in_ready=0 while rst=1.
- rst has priority over array_en.

## Timing
- Latency: a vector accepted at edge k appears on lane i after the (i+1)-th advance counting edge k as the first. With array_en held high, that is edge k+i.
- done rises after the advance that presents the last vector on lane NUM_LANES-1. With array_en high, that is edge k+NUM_LANES-1 for last accepted at edge k.
- in_ready is low from after the edge accepting last through the edge that sets done. It returns high in the cycle done is high, so a new tile may be accepted while done=1.
- Throughput: one vector per advance in IDLE and STREAM; there is no dead cycle between vectors.
- Drain length: NUM_LANES-1 advances.
- in_last without in_valid is ignored.

## Test plan
1. Reset: assert rst 2 cycles with random inputs and array_en=1. Required: out_data=0, out_valid=0000, done=0, in_ready=0 during reset. After release, in_ready=1.
2. Single vector, NUM_LANES=4: lanes 3..0 = 0x44,0x33,0x22,0x11 with in_last, accepted at edge 0. Required:
   - lane0 = 0x11 valid after edge 0; lane1 = 0x22 after edge 1; lane2 = 0x33 after edge 2; lane3 = 0x44 after edge 3.
   - done=1 after edge 3 only.
   - in_ready=0 after edges 0-2.
3. Back-to-back vectors A,B,C (C last) at edges 0,1,2. Required: lane j shows A,B,C after edges j, j+1, j+2; done after edge 5; no out_valid gaps on any lane.
4. Stall: array_en=0 for 2 cycles right after B is accepted in scenario 3. Required: all outputs frozen, in_ready=0 during the stall; done after edge 7.
5. Bubble: in_valid=0 for one cycle between A and B. Required: a single out_valid=0 on each lane, one cycle after A on that lane; in_ready stays 1.
6. Reset mid-DRAIN: assert rst one cycle after last is accepted in scenario 2. Required: all outputs 0 after the reset edge, done never pulses, in_ready=1 after release.
